// File: rtl/mc14500_pkg.sv
// Shared types for the MC14500B fetch sequencer: opcodes, PC commands and
// sequencer states.
package mc14500_pkg;

    typedef enum logic [3:0] {
        OP_NOPO = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_JMP  = 2'b01,
        PC_RTN  = 2'b10,
        PC_CALL = 2'b11
    } pc_cmd_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        SKIP  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mc14500_op_decode.sv
// Combinational opcode decoder for the MC14500B sequencer.
// Build option MC14500_SEQ_CALL_EN turns NOPF into a CALL (pc_cmd=11).
module mc14500_op_decode
    import mc14500_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [1:0] pc_cmd,
    output logic       op_valid,
    output logic       jmp_sel,
    output logic       rtn_sel,
    output logic       flag_o_sel,
    output logic       flag_f_sel,
    output logic       skip_always,
    output logic       skip_if_rr0
);

    always_comb begin
        pc_cmd      = PC_INC;
        op_valid    = 1'b0;
        jmp_sel     = 1'b0;
        rtn_sel     = 1'b0;
        flag_o_sel  = 1'b0;
        flag_f_sel  = 1'b0;
        skip_always = 1'b0;
        skip_if_rr0 = 1'b0;
        case (opcode)
            OP_NOPO: flag_o_sel = 1'b1;
            OP_JMP: begin
                jmp_sel = 1'b1;
                pc_cmd  = PC_JMP;
            end
            OP_RTN: begin
                rtn_sel     = 1'b1;
                pc_cmd      = PC_RTN;
                skip_always = 1'b1;
            end
            OP_SKZ: skip_if_rr0 = 1'b1;
            OP_NOPF: begin
                flag_f_sel = 1'b1;
`ifdef MC14500_SEQ_CALL_EN
                pc_cmd     = PC_CALL;
`else
                pc_cmd     = PC_INC;
`endif
            end
            default: op_valid = 1'b1;  // LD .. OEN go to the logic unit
        endcase
    end

endmodule

// File: rtl/mc14500_fetch_sequencer.sv
// MC14500B fetch/decode sequencer: FETCH -> WAIT -> EXEC|SKIP, Moore outputs.
// NOPF behaviour depends on MC14500_SEQ_CALL_EN (see mc14500_op_decode).
module mc14500_fetch_sequencer
    import mc14500_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = ADDR_WIDTH + 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_valid,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    input  logic                   rr,
    output logic [3:0]             op,
    output logic [ADDR_WIDTH-1:0]  operand,
    output logic                   op_valid,
    output logic [1:0]             pc_cmd,
    output logic                   pc_step,
    output logic                   jmp_flag,
    output logic                   rtn_flag,
    output logic                   flag_o,
    output logic                   flag_f
);

    seq_state_e             state_reg, state_next;
    logic                   skip_reg, skip_next;
    logic [INSTR_WIDTH-1:0] ir_reg, ir_next;

    logic [1:0] dec_pc_cmd;
    logic       dec_op_valid, dec_jmp, dec_rtn, dec_flag_o, dec_flag_f;
    logic       dec_skip_always, dec_skip_if_rr0;

    mc14500_op_decode u_decode (
        .opcode      (ir_reg[INSTR_WIDTH-1 -: 4]),
        .pc_cmd      (dec_pc_cmd),
        .op_valid    (dec_op_valid),
        .jmp_sel     (dec_jmp),
        .rtn_sel     (dec_rtn),
        .flag_o_sel  (dec_flag_o),
        .flag_f_sel  (dec_flag_f),
        .skip_always (dec_skip_always),
        .skip_if_rr0 (dec_skip_if_rr0)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= FETCH;
            skip_reg  <= 1'b0;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            skip_reg  <= skip_next;
            ir_reg    <= ir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        skip_next  = skip_reg;
        ir_next    = ir_reg;
        case (state_reg)
            FETCH: state_next = WAIT;
            WAIT: begin
                if (mem_valid) begin
                    if (skip_reg) begin
                        skip_next  = 1'b0;
                        state_next = SKIP;
                    end else begin
                        ir_next    = mem_data;
                        state_next = EXEC;
                    end
                end
            end
            EXEC: begin
                state_next = FETCH;
                // A single flag, not a counter: back-to-back setters still skip only one word
                if (dec_skip_always || (dec_skip_if_rr0 && !rr))
                    skip_next = 1'b1;
            end
            SKIP:    state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        op       = ir_reg[INSTR_WIDTH-1 -: 4];
        operand  = ir_reg[ADDR_WIDTH-1:0];
        op_valid = 1'b0;
        pc_cmd   = PC_INC;
        pc_step  = 1'b0;
        jmp_flag = 1'b0;
        rtn_flag = 1'b0;
        flag_o   = 1'b0;
        flag_f   = 1'b0;
        case (state_reg)
            FETCH: begin
                // Reset parks the FSM in FETCH; keep the request quiet while held in reset
                mem_req  = reset_n;
                mem_addr = reset_n ? pc_addr : '0;
            end
            EXEC: begin
                pc_step  = 1'b1;
                pc_cmd   = dec_pc_cmd;
                op_valid = dec_op_valid;
                jmp_flag = dec_jmp;
                rtn_flag = dec_rtn;
                flag_o   = dec_flag_o;
                flag_f   = dec_flag_f;
            end
            SKIP:    pc_step = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc14500_fetch_sequencer.sv
// Self-checking bench for mc14500_fetch_sequencer: directed steps plus random
// programs checked against an instruction-level reference model.
module tb_mc14500_fetch_sequencer;

    localparam int AW = 8;
    localparam int IW = AW + 4;
`ifdef MC14500_SEQ_CALL_EN
    localparam bit CALL_EN = 1'b1;
`else
    localparam bit CALL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] pc_addr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_valid;
    logic [IW-1:0] mem_data;
    logic          rr;
    logic [3:0]    op;
    logic [AW-1:0] operand;
    logic          op_valid;
    logic [1:0]    pc_cmd;
    logic          pc_step;
    logic          jmp_flag, rtn_flag, flag_o, flag_f;

    int errors = 0;
    int checks = 0;
    bit model_skip = 1'b0;

    mc14500_fetch_sequencer #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pc_addr   (pc_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .rr        (rr),
        .op        (op),
        .operand   (operand),
        .op_valid  (op_valid),
        .pc_cmd    (pc_cmd),
        .pc_step   (pc_step),
        .jmp_flag  (jmp_flag),
        .rtn_flag  (rtn_flag),
        .flag_o    (flag_o),
        .flag_f    (flag_f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   {mem_req, mem_addr}, 0);
        chk({tag, "_op"},    {op, operand}, 0);
        chk({tag, "_strb"},  {op_valid, pc_step, pc_cmd}, 0);
        chk({tag, "_flags"}, {jmp_flag, rtn_flag, flag_o, flag_f}, 0);
    endtask

    // Entered at a negedge in the FETCH cycle; returns at the negedge of the next FETCH.
    task automatic run_instr(input logic [IW-1:0] word, input int delay,
                             input logic rr_val, input logic [AW-1:0] pc);
        logic [3:0] opc;
        bit         skipped;
        logic [1:0] exp_cmd;
        logic [3:0] exp_flags;
        logic       exp_valid;
        opc     = word[IW-1 -: 4];
        pc_addr = pc;
        #1;
        chk("fetch_req", mem_req, 1);
        chk("fetch_addr", mem_addr, pc);
        @(negedge clk);
        for (int i = 0; i < delay; i++) begin
            chk("wait_quiet", {mem_req, op_valid, pc_step, jmp_flag, rtn_flag}, 0);
            @(negedge clk);
        end
        chk("wait_req_low", mem_req, 0);
        mem_valid = 1'b1;
        mem_data  = word;
        @(negedge clk);
        mem_valid = 1'b0;
        mem_data  = IW'($urandom);
        rr        = rr_val;
        skipped   = model_skip;
        if (skipped) begin
            model_skip = 1'b0;
            exp_cmd    = 2'd0;
            exp_flags  = 4'd0;
            exp_valid  = 1'b0;
        end else begin
            exp_valid = (opc >= 4'h1) && (opc <= 4'hB);
            exp_cmd   = (opc == 4'hC) ? 2'd1 :
                        (opc == 4'hD) ? 2'd2 :
                        (opc == 4'hF && CALL_EN) ? 2'd3 : 2'd0;
            exp_flags = {opc == 4'hC, opc == 4'hD, opc == 4'h0, opc == 4'hF};
        end
        #1;
        chk("exec_step", pc_step, 1);
        chk("exec_valid", op_valid, exp_valid);
        chk("exec_cmd", pc_cmd, exp_cmd);
        chk("exec_flags", {jmp_flag, rtn_flag, flag_o, flag_f}, exp_flags);
        chk("exec_req_low", mem_req, 0);
        if (!skipped) begin
            chk("exec_op", op, opc);
            chk("exec_operand", operand, word[AW-1:0]);
            if (opc == 4'hD || (opc == 4'hE && !rr_val))
                model_skip = 1'b1;
        end
        $display("instr word=0x%03h delay=%0d rr=%0d skipped=%0d op_valid=%0d pc_cmd=%0d",
                 word, delay, rr_val, skipped, op_valid, pc_cmd);
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        pc_addr   = 8'hA5;
        mem_valid = 1'b0;
        mem_data  = '0;
        rr        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed program from the test plan
        run_instr(12'h105, 0, 1'b0, 8'h00);  // LD 0x05
        run_instr(12'hC3A, 0, 1'b1, 8'h01);  // JMP 0x3A
        run_instr(12'hE00, 0, 1'b0, 8'h3A);  // SKZ with rr=0
        run_instr(12'h1AA, 0, 1'b1, 8'h3B);  // skipped
        run_instr(12'h2BB, 0, 1'b1, 8'h3C);  // executes
        run_instr(12'hE01, 0, 1'b1, 8'h3D);  // SKZ with rr=1
        run_instr(12'h1CC, 0, 1'b0, 8'h3E);  // executes
        run_instr(12'hD00, 0, 1'b0, 8'h3F);  // RTN
        run_instr(12'h3DD, 0, 1'b0, 8'h40);  // skipped
        run_instr(12'h4EE, 0, 1'b0, 8'h41);  // executes
        run_instr(12'h5FF, 4, 1'b0, 8'h42);  // four wait cycles
        run_instr(12'hF20, 1, 1'b0, 8'h43);  // NOPF
        run_instr(12'h077, 2, 1'b1, 8'h44);  // NOPO

        // Random programs
        for (int n = 0; n < 150; n++)
            run_instr(IW'($urandom), int'($urandom_range(0, 3)), 1'b1 & 1'($urandom), AW'($urandom));

        // Arm a skip, then reset mid-WAIT: the skip must be forgotten
        run_instr(12'hE10, 0, 1'b0, 8'h10);
        pc_addr = 8'h11;
        #1;
        chk("prereset_req", mem_req, 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midwait_reset");
        model_skip = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(12'h1A5, 0, 1'b0, 8'h00);
        run_instr(12'hB5A, 1, 1'b1, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc14500_fetch_sequencer.md
Name: mc14500_fetch_sequencer

Overview:
- Instruction fetch/control sequencer for the MC14500B core.
- Consumes the program-counter address, fetches the instruction word from program memory through a req/valid handshake, and decodes it.
- Issues the 2-bit PC command (INC/JMP/RTN/CALL) plus an update strobe back to the program counter.
- Drives the logic-unit opcode strobe and the JMP/RTN/FLAG_O/FLAG_F pins, and implements the SKZ/RTN skip rule.

Parameters:
- ADDR_WIDTH, 8, width of the program address and of the instruction operand field.
- INSTR_WIDTH, ADDR_WIDTH+4, instruction word width: opcode in [INSTR_WIDTH-1:ADDR_WIDTH], operand in [ADDR_WIDTH-1:0].

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc_addr  in  ADDR_WIDTH  current address from the program counter.
- mem_req  out  1  fetch request, one-cycle pulse.
- mem_addr  out  ADDR_WIDTH  fetch address, valid with mem_req.
- mem_valid  in  1  instruction word valid, one-cycle pulse.
- mem_data  in  INSTR_WIDTH  instruction word.
- rr  in  1  result register from the logic unit.
- op  out  4  opcode to the logic unit.
- operand  out  ADDR_WIDTH  operand field (I/O address or jump target).
- op_valid  out  1  logic-unit execute strobe.
- pc_cmd  out  2  command to the program counter: 00 INC, 01 JMP, 10 RTN, 11 CALL.
- pc_step  out  1  PC update enable; the PC acts on pc_cmd only when this is 1 (integration ties it to the PC clock enable).
- jmp_flag, rtn_flag, flag_o, flag_f  out  1 each  one-cycle MC14500B output pins.

Behaviour:
- Reset is asynchronous and active-low.
  - Reset values: state=FETCH, skip=0, instruction register=0.
  - All strobes and flags 0, pc_cmd=00, op=0, operand=0, mem_addr=0.
- Moore outputs: every output is a function of state and the registered instruction only.
- FETCH (1 cycle):
  - mem_req=1, mem_addr=pc_addr.
  - Next state WAIT.
- WAIT:
  - mem_valid=0: hold in WAIT, no timeout.
  - mem_valid=1 with skip=1: clear skip, discard the word, go to SKIP.
  - mem_valid=1 with skip=0: capture mem_data into the instruction register, go to EXEC.
  - mem_valid in any state other than WAIT is ignored.
- SKIP (1 cycle):
  - pc_cmd=00, pc_step=1, op_valid=0, no flags.
  - Next state FETCH.
- EXEC (1 cycle):
  - Every opcode: pc_step=1, op=opcode, operand=operand field. Next state FETCH.
  - 0x1–0xB (LD..OEN): op_valid=1, pc_cmd=00.
  - 0x0 NOPO: flag_o=1, pc_cmd=00, op_valid=0.
  - 0xC JMP: jmp_flag=1, pc_cmd=01.
  - 0xD RTN: rtn_flag=1, pc_cmd=10, skip<=1.
  - 0xE SKZ: pc_cmd=00; skip<=1 if rr==0, sampled in the EXEC cycle.
  - 0xF NOPF: see Optional Feature.
- Timing:
  - Minimum 3 cycles per instruction (FETCH, WAIT, EXEC) with zero-wait memory, i.e. mem_valid in the cycle after mem_req.
  - Each extra memory wait cycle adds 1 cycle.
- Skip rule: skip suppresses exactly one following instruction; it is not cumulative.
- Boundaries:
  - Address wrap, stack overflow and stack underflow are owned by the program counter; this block does not check them.
  - Reset asserted mid-WAIT returns to FETCH. Program memory must share reset_n; stale responses are not filtered.

Optional Feature:
- Macro: MC14500_SEQ_CALL_EN.
- Defined: NOPF is treated as CALL. EXEC drives pc_cmd=11 and flag_f=1; the operand is the call target.
- Undefined: NOPF drives pc_cmd=00 and flag_f=1 only. pc_cmd=11 is never produced.

Decomposition:
- mc14500_pkg holds:
  - opcode enum (NOPO..NOPF, 4 bits);
  - pc_cmd enum (PC_INC=2'b00, PC_JMP=2'b01, PC_RTN=2'b10, PC_CALL=2'b11);
  - sequencer state enum (FETCH, WAIT, EXEC, SKIP).
- One combinational sub-module, mc14500_op_decode: opcode -> {pc_cmd, op_valid, flag selects, sets_skip_unconditional, sets_skip_if_rr0}.

Test Plan:
- Reset, then release with pc_addr=0x00 and zero-wait memory returning LD (0x1, operand 0x05):
  - mem_req pulses in cycle 1;
  - in cycle 3, op_valid=1, op=1, operand=0x05, pc_step=1, pc_cmd=00.
- JMP word 0xC3A: jmp_flag=1, pc_cmd=01, operand=0x3A in EXEC.
- SKZ with rr=0, then LD word:
  - LD is fetched but enters SKIP: op_valid stays 0, pc_step=1, pc_cmd=00;
  - the next instruction executes normally.
  - Repeat with rr=1: LD executes.
- RTN (0xD):
  - rtn_flag=1, pc_cmd=10;
  - the following word is skipped with no op_valid;
  - the word after that executes.
- mem_valid delayed 4 cycles: state holds WAIT, no strobes, mem_req not reissued; EXEC follows in the cycle after mem_valid.
- NOPF (0xF20):
  - with MC14500_SEQ_CALL_EN: pc_cmd=11, flag_f=1;
  - without: pc_cmd=00, flag_f=1.
- Reset_n pulsed low mid-WAIT: all outputs return to 0 asynchronously; mem_req is reissued in the first cycle after release.
